uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter PKT_SIZE, default 8: data bits per frame (4..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per line bit (even, >=4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 32: entries in each of the RX and TX FIFOs (power of 2, >=2).
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: 1 or 2 stop bits.
REQ-006 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-008 SHALL have port io_rx  in  1  serial input, asynchronous to clock, idle high.
REQ-009 SHALL have port io_tx  out  1  serial output, idle high.
REQ-010 SHALL have port io_rxReq_pkt  out  PKT_SIZE  popped RX packet.
REQ-011 SHALL have port io_rxReq_req  in  1  pop request.
REQ-012 SHALL have port io_rxReq_ready  out  1  RX FIFO non-empty.
REQ-013 SHALL have port io_rxReq_done  out  1  one-cycle pulse: io_rxReq_pkt valid.
REQ-014 SHALL have port io_txReq_pkt  in  PKT_SIZE  packet to transmit.
REQ-015 SHALL have port io_txReq_req  in  1  push request.
REQ-016 SHALL have port io_txReq_ready  out  1  TX FIFO not full.
REQ-017 SHALL have port io_txReq_done  out  1  one-cycle pulse at end of each transmitted frame.
REQ-018 SHALL have ports io_parityErr, io_frameErr, io_overflow  out  1 each  one-cycle error pulses.

Function
REQ-019 Frame SHALL be: start bit 0, PKT_SIZE data bits MSB first, parity bit if PARITY!=0, STOP_BITS stop bits of 1; each bit exactly CLKS_PER_BIT cycles.
REQ-020 Parity bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-021 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START the cycle after TX FIFO non-empty, popping head; DATA->PARITY skipped when PARITY=0; STOP->IDLE after last stop bit, pulsing io_txReq_done that cycle.
REQ-022 Back-to-back frames SHALL have no idle gap: if FIFO non-empty at end of STOP, next START begins the following cycle.
REQ-023 io_txReq_req with io_txReq_ready=1 SHALL push io_txReq_pkt; push when full SHALL be ignored; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-024 io_rx SHALL pass a 2-flop synchroniser; RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-025 RX IDLE->START on synchronised 1->0 edge; at CLKS_PER_BIT/2 cycles later, line 1 SHALL return to IDLE (glitch, no error), line 0 SHALL proceed; every later bit sampled CLKS_PER_BIT cycles after previous sample.
REQ-026 Any stop bit sampled 0 SHALL pulse io_frameErr, discard frame, and return to IDLE only after line reads 1.
REQ-027 Parity mismatch SHALL pulse io_parityErr and discard frame; if both errors, both pulse.
REQ-028 Good frame with RX FIFO full SHALL pulse io_overflow, drop the frame, leave FIFO contents unchanged.
REQ-029 Good frame SHALL be written to RX FIFO in the cycle after its last stop-bit sample; io_rxReq_ready rises the next cycle.
REQ-030 io_rxReq_req with ready=1 SHALL pop; io_rxReq_pkt valid and io_rxReq_done=1 exactly one cycle later; pkt holds value until next pop; req when empty ignored, no done.
REQ-031 Simultaneous RX write and pop SHALL both take effect; pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-032 While reset=0: io_tx=1, both FSMs IDLE, both FIFOs empty, bit/baud counters 0, synchroniser flops 1, io_rxReq_pkt=0, all ready/done/error outputs 0 except io_txReq_ready=1.
REQ-033 Reset asserted mid-frame SHALL force io_tx=1 immediately (asynchronous) and discard partial frames and FIFO contents.
REQ-034 After reset release, RX SHALL not detect a start until io_rx has been sampled 1 by the synchroniser.

Verification (CLKS_PER_BIT=4, PKT_SIZE=8, FIFO_DEPTH=32 unless stated)
REQ-035 Inject 0xCD then 0xAA on io_rx, PARITY=0 -> ready rises; two pops return 0xCD then 0xAA, each with done one cycle after req.
REQ-036 Push 0xAA and 0x55 on consecutive cycles -> io_tx: 0,1,0,1,0,1,0,1,0,1 then 0,0,1,0,1,0,1,0,1,1, 4 cycles per bit, no gap, two done pulses.
REQ-037 PARITY=1, inject 0xAA with parity bit 1 -> io_parityErr pulse, ready stays 0; with parity bit 0 -> accepted.
REQ-038 Inject 0x3C with stop bit 0 -> io_frameErr pulse, nothing queued; following good 0x81 received correctly.
REQ-039 FIFO_DEPTH=2, inject 0x01, 0x02, 0x03 without popping -> io_overflow on third; pops return 0x01, 0x02, then ready=0.
REQ-040 Assert reset during DATA bit 3 of a TX frame -> io_tx=1 same cycle, no done, txReq_ready=1 after release.

Source files
------------

// File: rtl/uart_ctrl.sv
// UART controller: TX and RX FIFOs in front of a framed serial transmitter
// and an oversampling receiver. Frame = start, data MSB first, optional
// parity, one or two stop bits; every line bit lasts CLKS_PER_BIT clocks.
module uart_ctrl #(
  parameter int PKT_SIZE     = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_rx,
  output logic                io_tx,
  output logic [PKT_SIZE-1:0] io_rxReq_pkt,
  input  logic                io_rxReq_req,
  output logic                io_rxReq_ready,
  output logic                io_rxReq_done,
  input  logic [PKT_SIZE-1:0] io_txReq_pkt,
  input  logic                io_txReq_req,
  output logic                io_txReq_ready,
  output logic                io_txReq_done,
  output logic                io_parityErr,
  output logic                io_frameErr,
  output logic                io_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(PKT_SIZE);
  localparam logic [AW:0]   L_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] L_BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] L_HALF     = CW'(CLKS_PER_BIT/2-1);
  localparam logic [BW-1:0] L_LAST_BIT = BW'(PKT_SIZE-1);
  localparam logic          L_ODD      = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------- TX FIFO ----------------
  logic [PKT_SIZE-1:0] r_txm [FIFO_DEPTH];
  logic [AW-1:0]       r_tx_wp, r_tx_rp;
  logic [AW:0]         r_tx_cnt;
  logic [2:0]          r_tx_st;
  logic [CW-1:0]       r_tx_baud;
  logic [BW-1:0]       r_tx_bit;
  logic                r_tx_stop;
  logic [PKT_SIZE-1:0] r_tx_sh;
  logic                r_tx_par;

  logic                w_tx_push, w_tx_pop, w_tx_bit_end, w_tx_last;
  logic [PKT_SIZE-1:0] w_tx_head;

  assign io_txReq_ready = (r_tx_cnt != L_DEPTH);
  assign w_tx_push      = io_txReq_req && io_txReq_ready;
  assign w_tx_head      = r_txm[r_tx_rp];
  assign w_tx_bit_end   = (r_tx_baud == L_BIT_END);
  assign w_tx_last      = (r_tx_st == S_STOP) && w_tx_bit_end &&
                          ((STOP_BITS == 1) ? 1'b1 : r_tx_stop);
  // Head is popped when the FSM leaves IDLE or chains straight out of STOP.
  assign w_tx_pop       = ((r_tx_st == S_IDLE) || w_tx_last) && (r_tx_cnt != '0);
  assign io_txReq_done  = w_tx_last;

  // TX FIFO storage (contents need no reset; occupancy governs validity)
  always_ff @(posedge clock) begin
    if (w_tx_push) r_txm[r_tx_wp] <= io_txReq_pkt;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // TX frame sequencer; STOP chains into START when more data is queued
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_st   <= S_IDLE;
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
      r_tx_stop <= 1'b0;
      r_tx_sh   <= '0;
      r_tx_par  <= 1'b0;
    end else begin
      r_tx_baud <= ((r_tx_st == S_IDLE) || w_tx_bit_end) ? '0 : r_tx_baud + CW'(1);
      case (r_tx_st)
        S_IDLE: if (w_tx_pop) begin
          r_tx_st  <= S_START;
          r_tx_sh  <= w_tx_head;
          r_tx_par <= (^w_tx_head) ^ L_ODD;
        end
        S_START: if (w_tx_bit_end) begin
          r_tx_st  <= S_DATA;
          r_tx_bit <= '0;
        end
        S_DATA: if (w_tx_bit_end) begin
          r_tx_sh <= r_tx_sh << 1;
          if (r_tx_bit == L_LAST_BIT) begin
            r_tx_st   <= (PARITY != 0) ? S_PARITY : S_STOP;
            r_tx_stop <= 1'b0;
          end else begin
            r_tx_bit <= r_tx_bit + BW'(1);
          end
        end
        S_PARITY: if (w_tx_bit_end) begin
          r_tx_st   <= S_STOP;
          r_tx_stop <= 1'b0;
        end
        S_STOP: if (w_tx_bit_end) begin
          if (!w_tx_last) begin
            r_tx_stop <= 1'b1;
          end else if (w_tx_pop) begin
            r_tx_st  <= S_START;
            r_tx_sh  <= w_tx_head;
            r_tx_par <= (^w_tx_head) ^ L_ODD;
          end else begin
            r_tx_st <= S_IDLE;
          end
        end
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  // Line level is decoded from state so reset drives it high immediately
  always_comb begin
    io_tx = 1'b1;
    case (r_tx_st)
      S_START:  io_tx = 1'b0;
      S_DATA:   io_tx = r_tx_sh[PKT_SIZE-1];
      S_PARITY: io_tx = r_tx_par;
      default:  io_tx = 1'b1;
    endcase
  end

  // ---------------- RX front end ----------------
  logic [1:0] r_sync;
  logic [1:0] r_sv;
  logic       r_prev;
  logic       w_rx, w_fall;

  assign w_rx   = r_sync[1];
  // r_prev only goes high once a real line sample of 1 has left the
  // synchroniser, so a line held low through reset never looks like a start.
  assign w_fall = r_prev && !w_rx;

  // Synchroniser, sample-valid tracker and previous-level register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
      r_sv   <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], io_rx};
      r_sv   <= {r_sv[0], 1'b1};
      r_prev <= w_rx && r_sv[1];
    end
  end

  logic [2:0]          r_rx_st;
  logic [CW-1:0]       r_rx_baud;
  logic [BW-1:0]       r_rx_bit;
  logic                r_rx_stop, r_rx_perr, r_rx_ferr, r_rx_brk, r_rx_wr;
  logic [PKT_SIZE-1:0] r_rx_sh;
  logic                r_perr_p, r_ferr_p;
  logic                w_rx_tick, w_rx_last_stop, w_ferr_any;

  assign w_rx_tick      = (r_rx_baud == L_BIT_END);
  assign w_rx_last_stop = (STOP_BITS == 1) ? 1'b1 : r_rx_stop;
  assign w_ferr_any     = r_rx_ferr || !w_rx;
  assign io_parityErr   = r_perr_p;
  assign io_frameErr    = r_ferr_p;

  // RX frame sampler: mid-bit sampling, error pulses, write request on good frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_st   <= S_IDLE;
      r_rx_baud <= '0;
      r_rx_bit  <= '0;
      r_rx_stop <= 1'b0;
      r_rx_perr <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_brk  <= 1'b0;
      r_rx_wr   <= 1'b0;
      r_rx_sh   <= '0;
      r_perr_p  <= 1'b0;
      r_ferr_p  <= 1'b0;
    end else begin
      r_rx_wr  <= 1'b0;
      r_perr_p <= 1'b0;
      r_ferr_p <= 1'b0;
      case (r_rx_st)
        S_IDLE: begin
          r_rx_baud <= '0;
          r_rx_perr <= 1'b0;
          r_rx_ferr <= 1'b0;
          if (w_fall) r_rx_st <= S_START;
        end
        S_START: if (r_rx_baud == L_HALF) begin
          r_rx_baud <= '0;
          r_rx_bit  <= '0;
          r_rx_st   <= w_rx ? S_IDLE : S_DATA;
        end else r_rx_baud <= r_rx_baud + CW'(1);
        S_DATA: if (w_rx_tick) begin
          r_rx_baud <= '0;
          r_rx_sh   <= {r_rx_sh[PKT_SIZE-2:0], w_rx};
          if (r_rx_bit == L_LAST_BIT) begin
            r_rx_st   <= (PARITY != 0) ? S_PARITY : S_STOP;
            r_rx_stop <= 1'b0;
          end else r_rx_bit <= r_rx_bit + BW'(1);
        end else r_rx_baud <= r_rx_baud + CW'(1);
        S_PARITY: if (w_rx_tick) begin
          r_rx_baud <= '0;
          r_rx_perr <= (w_rx != ((^r_rx_sh) ^ L_ODD));
          r_rx_st   <= S_STOP;
          r_rx_stop <= 1'b0;
        end else r_rx_baud <= r_rx_baud + CW'(1);
        S_STOP: if (r_rx_brk) begin
          // Broken frame: wait for the line to recover before hunting again
          if (w_rx) begin
            r_rx_brk <= 1'b0;
            r_rx_st  <= S_IDLE;
          end
        end else if (w_rx_tick) begin
          r_rx_baud <= '0;
          if (w_rx_last_stop) begin
            r_ferr_p <= w_ferr_any;
            r_perr_p <= r_rx_perr;
            r_rx_wr  <= !w_ferr_any && !r_rx_perr;
            if (w_ferr_any) r_rx_brk <= 1'b1;
            else            r_rx_st  <= S_IDLE;
          end else begin
            r_rx_ferr <= w_ferr_any;
            r_rx_stop <= 1'b1;
          end
        end else r_rx_baud <= r_rx_baud + CW'(1);
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [PKT_SIZE-1:0] r_rxm [FIFO_DEPTH];
  logic [AW-1:0]       r_rx_wp, r_rx_rp;
  logic [AW:0]         r_rx_cnt;
  logic [PKT_SIZE-1:0] r_pkt;
  logic                r_done, r_ovf;
  logic                w_rx_full, w_rx_push, w_rx_pop;

  assign w_rx_full      = (r_rx_cnt == L_DEPTH);
  assign w_rx_push      = r_rx_wr && !w_rx_full;
  assign w_rx_pop       = io_rxReq_req && (r_rx_cnt != '0);
  assign io_rxReq_ready = (r_rx_cnt != '0);
  assign io_rxReq_pkt   = r_pkt;
  assign io_rxReq_done  = r_done;
  assign io_overflow    = r_ovf;

  // RX FIFO storage
  always_ff @(posedge clock) begin
    if (w_rx_push) r_rxm[r_rx_wp] <= r_rx_sh;
  end

  // RX FIFO pointers, occupancy, pop data register and overflow pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_pkt    <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_rx_pop;
      r_ovf  <= r_rx_wr && w_rx_full;
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop) begin
        r_rx_rp <= r_rx_rp + AW'(1);
        r_pkt   <= r_rxm[r_rx_rp];
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule
